// File: rtl/bus_seg_led_slave.sv
// Peripheral-bus responder: LED, 7-segment and control registers, switch status, 4-digit display scan.
// Latency: register write at the bus edge, display/LED outputs follow one edge later; read data one edge after the read.
// Backpressure: none; every selected cycle completes immediately, so the bus never waits.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   bus_sel/bus_w   device select (bit SEL_BIT) and write strobe
//   bus_addr        byte address, only [3:2] decoded
//   bus_wdata       write data; bus_rdata registered read data (0 when not reading)
//   SW              raw slide switches, synchronised before use
//   led_data        LED drive (active-high)
//   segment_data    {dp,g,f,e,d,c,b,a} active-low; AN active-low anodes, AN[0] rightmost
module bus_seg_led_slave #(
   parameter int SEL_BIT  = 0,
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bus_sel,
   input  logic        bus_w,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   input  logic [2:0]  SW,
   output logic [7:0]  led_data,
   output logic [7:0]  segment_data,
   output logic [3:0]  AN
);

   localparam int               CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [7:0]       led_reg;
   logic [15:0]      seg_reg;
   logic [8:0]       ctrl_reg;
   logic [2:0]       sw_meta;
   logic [2:0]       sw_sync;
   logic [CNT_W-1:0] scan_cnt;
   logic [1:0]       digit_idx;

   logic             dev_sel;
   logic             wr_en;
   logic             rd_en;
   logic [1:0]       reg_idx;
   logic [31:0]      rd_mux;
   logic [3:0]       cur_nib;
   logic [3:0]       dp_bits;
   logic             unused_bits;

   assign dev_sel = bus_sel[SEL_BIT];
   assign wr_en   = dev_sel & bus_w;
   assign rd_en   = dev_sel & ~bus_w;
   assign reg_idx = bus_addr[3:2];
   assign cur_nib = seg_reg[{digit_idx, 2'b00} +: 4];
   assign dp_bits = ctrl_reg[7:4];

   // Other select bits, undecoded address bits and high write-data bits are don't-care.
   assign unused_bits = ^{bus_sel, bus_addr[31:4], bus_addr[1:0], bus_wdata[31:16]};

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      hex7 = 7'h7F;
      case (nib)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         4'hF: hex7 = 7'h0E;
         default: hex7 = 7'h7F;
      endcase
   endfunction

   // Read mux sees register state before any write landing on the same edge.
   always_comb begin
      rd_mux = '0;
      case (reg_idx)
         2'd0: rd_mux = {24'd0, led_reg};
         2'd1: rd_mux = {16'd0, seg_reg};
         2'd2: rd_mux = {23'd0, ctrl_reg};
         2'd3: rd_mux = {29'd0, sw_sync};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_reg   <= '0;
         seg_reg   <= '0;
         ctrl_reg  <= 9'h00F;
         bus_rdata <= '0;
         sw_meta   <= '0;
         sw_sync   <= '0;
      end else begin
         if (wr_en) begin
            case (reg_idx)
               2'd0:    led_reg  <= bus_wdata[7:0];
               2'd1:    seg_reg  <= bus_wdata[15:0];
               2'd2:    ctrl_reg <= bus_wdata[8:0];
               default: ;  // STAT is read-only
            endcase
         end
         bus_rdata <= rd_en ? rd_mux : 32'd0;
         sw_meta   <= SW;
         sw_sync   <= sw_meta;
      end
   end

   // Digit slot timer: each digit is held for SCAN_DIV clocks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
      end else if (scan_cnt == CNT_LAST) begin
         scan_cnt  <= '0;
         digit_idx <= digit_idx + 2'd1;
      end else begin
         scan_cnt  <= scan_cnt + 1'b1;
      end
   end

   // Display and LED outputs are registered from the current digit index.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_data     <= '0;
         segment_data <= 8'hFF;
         AN           <= 4'hF;
      end else begin
         led_data     <= led_reg;
         segment_data <= {~dp_bits[digit_idx], hex7(cur_nib)};
         AN           <= ctrl_reg[8] ? 4'hF : ~((4'b0001 << digit_idx) & ctrl_reg[3:0]);
      end
   end

endmodule

// File: tb/tb_bus_seg_led_slave.sv
`timescale 1ns/1ps
module tb_bus_seg_led_slave;

   localparam int SEL = 3;
   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bus_sel;
   logic        bus_w;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic [2:0]  SW;
   logic [7:0]  led_data;
   logic [7:0]  segment_data;
   logic [3:0]  AN;

   always #5 clk = ~clk;

   bus_seg_led_slave #(.SEL_BIT(SEL), .SCAN_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .bus_sel(bus_sel), .bus_w(bus_w), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .SW(SW), .led_data(led_data),
      .segment_data(segment_data), .AN(AN)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [3:0]  an;
      logic [7:0]  seg;
      logic [7:0]  led;
      logic [31:0] rdata;
   } exp_t;

   exp_t exp_q[$];

   logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [7:0]  m_led;
   logic [15:0] m_seg;
   logic [8:0]  m_ctrl;
   logic [2:0]  sw_d1, sw_d2;   // SW as seen one and two edges back
   int          n_edges;        // edges since reset release

   // Predicts what the DUT shows after each edge from register contents and elapsed time.
   always @(posedge clk or negedge rst) begin
      exp_t e;
      int   di;
      int   nib;
      if (!rst) begin
         m_led = 8'h00; m_seg = 16'h0000; m_ctrl = 9'h00F;
         sw_d1 = 3'd0; sw_d2 = 3'd0; n_edges = 0;
         exp_q.delete();
      end else begin
         di  = (n_edges / DIV) % 4;
         nib = (m_seg >> (4 * di)) & 16'hF;
         for (int d = 0; d < 4; d++)
            e.an[d] = m_ctrl[8] ? 1'b1 : !((d == di) && m_ctrl[d]);
         e.seg   = {~m_ctrl[4 + di], hex_tab[nib]};
         e.led   = m_led;
         e.rdata = 32'd0;
         if (bus_sel[SEL] && !bus_w) begin
            case (bus_addr[3:2])
               2'd0: e.rdata = {24'd0, m_led};
               2'd1: e.rdata = {16'd0, m_seg};
               2'd2: e.rdata = {23'd0, m_ctrl};
               default: e.rdata = {29'd0, sw_d2};
            endcase
         end
         if (bus_sel[SEL] && bus_w) begin
            case (bus_addr[3:2])
               2'd0: m_led  = bus_wdata[7:0];
               2'd1: m_seg  = bus_wdata[15:0];
               2'd2: m_ctrl = bus_wdata[8:0];
               default: ;
            endcase
         end
         sw_d2 = sw_d1;
         sw_d1 = SW;
         n_edges++;
         exp_q.push_back(e);
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         chk("reset_an", {28'd0, AN}, 32'hF);
         chk("reset_seg", {24'd0, segment_data}, 32'hFF);
         chk("reset_led", {24'd0, led_data}, 32'h0);
         chk("reset_rdata", bus_rdata, 32'h0);
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("an", {28'd0, AN}, {28'd0, e.an});
         chk("segment_data", {24'd0, segment_data}, {24'd0, e.seg});
         chk("led_data", {24'd0, led_data}, {24'd0, e.led});
         chk("bus_rdata", bus_rdata, e.rdata);
      end
   end

   // ---------------- stimulus ----------------
   localparam logic [31:0] SEL_MASK = 32'd1 << SEL;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus_sel   = $urandom & ~SEL_MASK;
      bus_w     = 1'($urandom);
      bus_addr  = $urandom;
      bus_wdata = $urandom;
   endtask

   task automatic wait_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         idle();
         step();
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus_sel   = SEL_MASK | ($urandom & 32'hFFFF_0000);
      bus_w     = 1'b1;
      bus_addr  = a;
      bus_wdata = d;
      step();
      idle();
   endtask

   task automatic rd(input logic [31:0] a);
      bus_sel   = SEL_MASK | ($urandom & 32'h0000_0F00);
      bus_w     = 1'b0;
      bus_addr  = a;
      bus_wdata = $urandom;
      step();
      idle();
   endtask

   task automatic release_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      step();
   endtask

   initial begin
      bool_found: begin end
      rst = 1'b0;
      SW  = 3'd0;
      idle();
      repeat (3) @(posedge clk);
      release_reset();           // first edge after release must show AN=E

      // LED write/read with upper data bits discarded
      wr(32'h0, 32'h1A5);
      wait_cycles(2);
      rd(32'h0);
      rd(32'h3);                 // addr[1:0] ignored

      // scan with a four-digit pattern
      wr(32'h4, 32'h1234);
      wait_cycles(40);

      // digit enables, decimal points, blanking
      wr(32'h8, 32'h025);
      wait_cycles(20);
      wr(32'h8, 32'h015);
      wait_cycles(20);
      wr(32'h8, 32'h125);
      wait_cycles(10);
      rd(32'h8);
      wr(32'h8, 32'h00F);

      // switch status, read-only STAT, deselected write
      SW = 3'b101;
      wait_cycles(3);
      rd(32'hC);
      wr(32'hC, 32'h7);
      rd(32'hC);
      bus_sel = ~SEL_MASK; bus_w = 1'b1; bus_addr = 32'h0; bus_wdata = 32'hFF;
      step();
      rd(32'h0);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 7) == 0) SW = 3'($urandom);
         case ($urandom_range(0, 3))
            0: wr({$urandom_range(0, 65535), 2'($urandom), 2'($urandom)}, $urandom);
            1: rd($urandom);
            default: wait_cycles(1);
         endcase
      end

      // reset in the middle of the scan while digit 2 is active
      wr(32'h4, 32'hBEEF);
      begin
         int guard = 0;
         while (((n_edges / DIV) % 4) != 2 && guard < 40) begin
            wait_cycles(1);
            guard++;
         end
         if (guard >= 40) chk("wait_digit2_timeout", 32'd1, 32'd0);
      end
      rst = 1'b0;
      #1;
      chk("midscan_an", {28'd0, AN}, 32'hF);
      chk("midscan_seg", {24'd0, segment_data}, 32'hFF);
      chk("midscan_led", {24'd0, led_data}, 32'h0);
      repeat (2) @(posedge clk);
      release_reset();
      rd(32'h0);
      rd(32'h4);
      rd(32'h8);
      rd(32'hC);
      wait_cycles(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
